dac_spi_frame_decoder: RTL and testbench

Receive-side decoder for the AD5662 3-wire DAC interface (SYNC/SCLK/DIN) produced by the audio/monitor DAC transmitter. It samples the serial lines on dataclk and reconstructs each 24-bit write frame into power-down mode plus 16-bit DAC code. It flags aborted, overrun and stalled frames. It sits beside each DAC output in debug/loopback builds so the transmitted code can be read back, counted and compared in simulation or on hardware.

---
 rtl/dac_spi_frame_decoder.sv | 154 +++++++++++++++
 tb/tb_dac_spi_frame_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_frame_decoder.sv
// Receive-side decoder for the AD5662 SYNC/SCLK/DIN write frame.
// Recovers header, power-down mode and DAC code; flags aborted, overrun and stalled frames.
module dac_spi_frame_decoder #(
    parameter int INPUT_SYNC     = 1,
    parameter int FRAME_BITS     = 24,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        dataclk,
    input  logic        reset,
    input  logic        dac_sync,
    input  logic        dac_sclk,
    input  logic        dac_din,
    output logic [15:0] dac_value,
    output logic [15:0] dac_value_twos_comp,
    output logic [1:0]  pd_mode,
    output logic [5:0]  header_bits,
    output logic        frame_valid,
    output logic        frame_abort,
    output logic        frame_overrun,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT, HOLD} state_t;

    state_t           state, state_n;
    logic [2:0]       line_in, line_s;
    logic [1:0]       line_d;
    logic             s_sync, s_sclk, s_din;
    logic             sclk_fall, sync_fall, sync_rise;
    logic [CNT_W-1:0] bit_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [23:0]      shift_reg, shift_next;
    logic             start, shift_en, latch, tmo_clr, abort_n, overrun_n;

    assign line_in = {dac_sync, dac_sclk, dac_din};

    generate
        if (INPUT_SYNC != 0) begin : g_sync2
            logic [2:0] line_meta;
            always_ff @(posedge dataclk) begin
                if (reset) begin
                    line_meta <= '0;
                    line_s    <= '0;
                end else begin
                    line_meta <= line_in;
                    line_s    <= line_meta;
                end
            end
        end else begin : g_sync1
            always_ff @(posedge dataclk) begin
                if (reset) line_s <= '0;
                else       line_s <= line_in;
            end
        end
    endgenerate

    always_ff @(posedge dataclk) begin
        if (reset) line_d <= '0;
        else       line_d <= line_s[2:1];
    end

    assign s_sync     = line_s[2];
    assign s_sclk     = line_s[1];
    assign s_din      = line_s[0];
    assign sclk_fall  = line_d[0] & ~s_sclk;
    assign sync_fall  = line_d[1] & ~s_sync;
    assign sync_rise  = ~line_d[1] & s_sync;
    assign shift_next = {shift_reg[22:0], s_din};

    // sync_rise outranks a coincident sclk_fall, so an edge landing with SYNC rising is never counted
    always_comb begin
        state_n   = state;
        start     = 1'b0;
        shift_en  = 1'b0;
        latch     = 1'b0;
        tmo_clr   = 1'b0;
        abort_n   = 1'b0;
        overrun_n = 1'b0;
        case (state)
            IDLE:  if (s_sync) state_n = ARMED;
            ARMED: if (sync_fall) begin
                start   = 1'b1;
                state_n = SHIFT;
            end
            SHIFT: begin
                if (sync_rise) begin
                    abort_n = 1'b1;
                    state_n = ARMED;
                end else if (sclk_fall) begin
                    shift_en = 1'b1;
                    tmo_clr  = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        latch   = 1'b1;
                        state_n = HOLD;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    abort_n = 1'b1;
                    state_n = IDLE;
                end
            end
            HOLD: begin
                if (sync_rise)      state_n   = ARMED;
                else if (sclk_fall) overrun_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge dataclk) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            tmo_cnt       <= '0;
            shift_reg     <= '0;
            dac_value     <= 16'h8000;
            pd_mode       <= '0;
            header_bits   <= '0;
            frame_valid   <= 1'b0;
            frame_abort   <= 1'b0;
            frame_overrun <= 1'b0;
            frame_count   <= '0;
        end else begin
            state         <= state_n;
            frame_valid   <= latch;
            frame_abort   <= abort_n;
            frame_overrun <= overrun_n;
            if (start) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (shift_en) begin
                bit_cnt   <= bit_cnt + 1'b1;
                shift_reg <= shift_next;
            end
            if (start || tmo_clr)  tmo_cnt <= '0;
            else if (state == SHIFT) tmo_cnt <= tmo_cnt + 1'b1;
            if (latch) begin
                header_bits <= shift_next[23:18];
                pd_mode     <= shift_next[17:16];
                dac_value   <= shift_next[15:0];
                frame_count <= frame_count + 1'b1;
            end
        end
    end

    assign dac_value_twos_comp = {~dac_value[15], dac_value[14:0]};
    assign busy                = (state == SHIFT) || (state == HOLD);

endmodule

// File: tb/tb_dac_spi_frame_decoder.sv
// Randomised frame-level bench for dac_spi_frame_decoder against a transaction model.
module tb_dac_spi_frame_decoder;

    localparam int TMO = 4096;

    logic        dataclk = 1'b0;
    logic        reset, dac_sync, dac_sclk, dac_din;
    logic [15:0] dac_value, dac_value_twos_comp, frame_count;
    logic [1:0]  pd_mode;
    logic [5:0]  header_bits;
    logic        frame_valid, frame_abort, frame_overrun, busy;

    dac_spi_frame_decoder #(
        .INPUT_SYNC    (1),
        .FRAME_BITS    (24),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .dataclk            (dataclk),
        .reset              (reset),
        .dac_sync           (dac_sync),
        .dac_sclk           (dac_sclk),
        .dac_din            (dac_din),
        .dac_value          (dac_value),
        .dac_value_twos_comp(dac_value_twos_comp),
        .pd_mode            (pd_mode),
        .header_bits        (header_bits),
        .frame_valid        (frame_valid),
        .frame_abort        (frame_abort),
        .frame_overrun      (frame_overrun),
        .frame_count        (frame_count),
        .busy               (busy)
    );

    always #5 dataclk = ~dataclk;

    int n_tests = 0;
    int n_fail  = 0;
    int mv, ma, mo, mboth;

    logic [15:0] exp_val, exp_cnt;
    logic [1:0]  exp_pd;
    logic [5:0]  exp_hdr;

    always @(negedge dataclk) begin
        if (frame_valid)                mv++;
        if (frame_abort)                ma++;
        if (frame_overrun)              mo++;
        if (frame_valid && frame_abort) mboth++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge dataclk);
        #1;
    endtask

    task automatic clear_mon();
        mv = 0; ma = 0; mo = 0; mboth = 0;
    endtask

    task automatic model_reset();
        exp_val = 16'h8000; exp_pd = '0; exp_hdr = '0; exp_cnt = '0;
    endtask

    task automatic model_frame(input logic [23:0] w);
        exp_hdr = w[23:18]; exp_pd = w[17:16]; exp_val = w[15:0]; exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic send_bits(input logic [23:0] w, input int nb, input int h);
        for (int i = 0; i < nb; i++) begin
            dac_din  = w[23-i];
            dac_sclk = 1'b1;
            step(h);
            dac_sclk = 1'b0;
            step(h);
        end
    endtask

    task automatic begin_frame(input int h);
        clear_mon();
        dac_sync = 1'b0;
        step(h);
    endtask

    task automatic end_frame();
        dac_sync = 1'b1;
        step(8);
    endtask

    task automatic check_txn(input string tag, input int ev, input int ea, input int eo);
        check({tag, ".valid_pulses"},   mv, ev);
        check({tag, ".abort_pulses"},   ma, ea);
        check({tag, ".overrun_pulses"}, mo, eo);
        check({tag, ".valid_and_abort"}, mboth, 0);
        check({tag, ".dac_value"},      dac_value, exp_val);
        check({tag, ".twos_comp"},      dac_value_twos_comp, exp_val ^ 16'h8000);
        check({tag, ".pd_mode"},        pd_mode, exp_pd);
        check({tag, ".header_bits"},    header_bits, exp_hdr);
        check({tag, ".frame_count"},    frame_count, exp_cnt);
        check({tag, ".busy"},           busy, 1'b0);
    endtask

    task automatic full_frame(input string tag, input logic [23:0] w, input int extra, input int h);
        begin_frame(h);
        send_bits(w, 24, h);
        send_bits(24'($urandom), extra, h);
        end_frame();
        model_frame(w);
        check_txn(tag, 1, 0, extra);
    endtask

    initial begin
        logic [23:0] w;
        int          k, h, kind;

        reset = 1'b1; dac_sync = 1'b1; dac_sclk = 1'b0; dac_din = 1'b0;
        model_reset();
        clear_mon();
        step(3);
        check("reset.dac_value",  dac_value, 16'h8000);
        check("reset.twos_comp",  dac_value_twos_comp, 16'h0000);
        check("reset.pd_mode",    pd_mode, 2'b00);
        check("reset.header",     header_bits, 6'd0);
        check("reset.count",      frame_count, 16'd0);
        check("reset.busy",       busy, 1'b0);
        check("reset.pulses",     {frame_valid, frame_abort, frame_overrun}, 3'b000);
        reset = 1'b0;
        step(6);

        full_frame("a5c3", {6'b0, 2'b00, 16'hA5C3}, 0, 2);
        check("a5c3.twos_exact", dac_value_twos_comp, 16'h25C3);

        begin_frame(2);
        send_bits({6'h15, 2'b10, 16'h1234}, 10, 2);
        end_frame();
        check_txn("abort10", 0, 1, 0);

        full_frame("v0001", {6'b0, 2'b00, 16'h0001}, 0, 2);
        full_frame("ffff_ovr", {6'h3F, 2'b11, 16'hFFFF}, 3, 2);

        begin_frame(1);
        end_frame();
        check_txn("glitch", 0, 1, 0);

        begin_frame(2);
        send_bits({6'h2A, 2'b01, 16'h4444}, 5, 2);
        step(TMO + 20);
        check("timeout.abort_pulses", ma, 1);
        check("timeout.idle", busy, 1'b0);
        end_frame();
        check_txn("timeout_after", 0, 1, 0);
        full_frame("v7fff", {6'b0, 2'b00, 16'h7FFF}, 0, 2);

        begin_frame(2);
        w = {6'h11, 2'b10, 16'hBEEF};
        send_bits(w, 12, 2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        send_bits(w << 12, 12, 2);
        end_frame();
        model_reset();
        check_txn("rst_mid", 0, 0, 0);
        full_frame("after_rst", {6'h05, 2'b01, 16'h3C3C}, 0, 2);

        force dut.frame_count = 16'hFFFF;
        step(1);
        release dut.frame_count;
        step(1);
        exp_cnt = 16'hFFFF;
        full_frame("wrap", {6'h00, 2'b00, 16'h0F0F}, 0, 1);

        for (int t = 0; t < 40; t++) begin
            w    = 24'($urandom);
            h    = $urandom_range(1, 3);
            kind = $urandom_range(0, 9);
            if (kind < 3) begin
                k = $urandom_range(0, 23);
                begin_frame(h);
                send_bits(w, k, h);
                end_frame();
                check_txn("rnd_abort", 0, 1, 0);
            end else begin
                full_frame("rnd_frame", w, (kind > 7) ? $urandom_range(1, 3) : 0, h);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
